// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared types and constants for the RV32I front end
package rv32i_pkg;
  typedef enum logic [1:0] {IDLE, REQ, HOLD, HALT} fetch_state_t;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;
  localparam int PC_STEP = 4;
endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I fetch stage, owns the PC and fetches words over a req/ack handshake
// Ports: clk/nRst (sync active-low reset); stall from decode; redirect/redirect_pc from execute;
//   imem_req/imem_addr/imem_ack/imem_rdata to instruction memory;
//   instruction/pc_out/instr_valid to control_unit; misaligned only with FETCH_MISALIGN_TRAP_EN.
// FETCH_MISALIGN_TRAP_EN: misaligned redirect targets trap into a sticky HALT state;
//   without it the low two target bits are cleared.
module fetch_unit
  import rv32i_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               nRst,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instruction,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               instr_valid
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic               misaligned
`endif
);
  fetch_state_t state_q;
  logic [ADDR_W-1:0] pc_q, pc_pend_q, pc_out_q, tgt;
  logic [INSTR_W-1:0] instr_q;
  logic kill_q, valid_q, bad, take, halting;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic mis_q;
  assign bad = redirect_pc[1:0] != 2'b00;
  assign take = redirect && !mis_q;
  assign halting = mis_q;
  assign tgt = redirect_pc;
  assign misaligned = mis_q;
`else
  assign bad = 1'b0;
  assign take = redirect;
  assign halting = 1'b0;
  assign tgt = redirect_pc & ~ADDR_W'(3);
`endif
  assign imem_req = state_q == REQ;
  assign imem_addr = pc_q;
  assign instruction = instr_q;
  assign pc_out = pc_out_q;
  assign instr_valid = valid_q;
  // kill_q marks an in-flight request whose data must be dropped; the
  // address stays put until ack, so the new target waits in pc_pend_q.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
      pc_pend_q <= RESET_PC;
      kill_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc_out_q <= RESET_PC;
      valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      mis_q <= 1'b0;
`endif
    end else begin
`ifdef FETCH_MISALIGN_TRAP_EN
      if (take && bad) mis_q <= 1'b1;
`endif
      case (state_q)
        IDLE: begin
          state_q <= (take && bad) ? HALT : REQ;
          if (take && !bad) pc_q <= tgt;
        end
        REQ: begin
          if (imem_ack) begin
            if (take) begin
              kill_q <= 1'b0;
              state_q <= bad ? HALT : REQ;
              if (!bad) pc_q <= tgt;
            end else if (kill_q) begin
              kill_q <= 1'b0;
              state_q <= halting ? HALT : REQ;
              if (!halting) pc_q <= pc_pend_q;
            end else begin
              instr_q <= imem_rdata;
              pc_out_q <= pc_q;
              valid_q <= 1'b1;
              pc_q <= pc_q + ADDR_W'(PC_STEP);
              state_q <= HOLD;
            end
          end else if (take) begin
            pc_pend_q <= tgt;
            kill_q <= 1'b1;
          end
        end
        HOLD: begin
          if (take) begin
            valid_q <= 1'b0;
            state_q <= bad ? HALT : REQ;
            if (!bad) pc_q <= tgt;
          end else if (!stall) begin
            valid_q <= 1'b0;
            state_q <= REQ;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against a transaction-level model
module tb_fetch_unit;
  import rv32i_pkg::*;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic nRst, stall, redirect, imem_ack;
  logic [31:0] redirect_pc, imem_rdata;
  logic imem_req, instr_valid;
  logic [31:0] imem_addr, instruction, pc_out;
  logic req2, valid2;
  logic [31:0] addr2, instr2, pc2;
  logic zero = 1'b0, one = 1'b1;
  logic [31:0] zero32 = '0, rd2 = 32'h0010_0093;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic misaligned, mis2;
`endif
  int checks = 0, failures = 0;

  fetch_unit dut (
    .clk(clk), .nRst(nRst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instruction(instruction), .pc_out(pc_out), .instr_valid(instr_valid)
`ifdef FETCH_MISALIGN_TRAP_EN
    , .misaligned(misaligned)
`endif
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .nRst(nRst), .stall(zero), .redirect(zero), .redirect_pc(zero32),
    .imem_req(req2), .imem_addr(addr2), .imem_ack(one), .imem_rdata(rd2),
    .instruction(instr2), .pc_out(pc2), .instr_valid(valid2)
`ifdef FETCH_MISALIGN_TRAP_EN
    , .misaligned(mis2)
`endif
  );

  // Reference model: fresh = first cycle after reset, busy = a request is
  // outstanding, drop = the outstanding word must be discarded.
  bit m_fresh, m_busy, m_valid, m_drop, m_mis;
  logic [31:0] m_pc, m_pend, m_instr, m_pcout;

  task automatic model_step();
    logic [31:0] t;
    bit bad, take;
`ifdef FETCH_MISALIGN_TRAP_EN
    bad = redirect_pc[1:0] != 2'b00;
    t = redirect_pc;
`else
    bad = 1'b0;
    t = {redirect_pc[31:2], 2'b00};
`endif
    take = redirect && !m_mis;
    if (!nRst) begin
      m_fresh = 1; m_busy = 0; m_valid = 0; m_drop = 0; m_mis = 0;
      m_pc = 32'h0; m_instr = NOP_INSTR; m_pcout = 32'h0;
    end else if (m_fresh) begin
      m_fresh = 0;
      if (take && bad) m_mis = 1;
      else begin m_busy = 1; if (take) m_pc = t; end
    end else if (m_busy) begin
      if (imem_ack) begin
        if (take) begin
          m_drop = 0;
          if (bad) begin m_mis = 1; m_busy = 0; end else m_pc = t;
        end else if (m_drop) begin
          m_drop = 0;
          if (m_mis) m_busy = 0; else m_pc = m_pend;
        end else begin
          m_instr = imem_rdata; m_pcout = m_pc; m_valid = 1; m_pc = m_pc + 32'd4; m_busy = 0;
        end
      end else if (take) begin
        m_pend = t; m_drop = 1;
        if (bad) m_mis = 1;
      end
    end else if (m_valid) begin
      if (take) begin
        m_valid = 0;
        if (bad) m_mis = 1; else begin m_pc = t; m_busy = 1; end
      end else if (!stall) begin
        m_valid = 0; m_busy = 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    nRst = 0; stall = 0; redirect = 0; redirect_pc = 0; imem_ack = 0; imem_rdata = 0;
    tick(); tick();
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctl: req=%b addr=%h valid=%b, want 0 00000000 0", imem_req, imem_addr, instr_valid);
    end
    checks++;
    if (instruction !== NOP_INSTR || pc_out !== 32'h0) begin
      failures++;
      $display("FAIL reset_data: instr=%h pc_out=%h, want 00000013 00000000", instruction, pc_out);
    end
  endtask

  task automatic test_zero_wait();
    imem_ack = 1; imem_rdata = 32'h0010_0093; nRst = 1;
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL first_req: req=%b addr=%h valid=%b, want 1 00000000 0", imem_req, imem_addr, instr_valid);
    end
    tick();
    checks++;
    if (instr_valid !== 1'b1 || instruction !== 32'h0010_0093 || pc_out !== 32'h0 || imem_req !== 1'b0) begin
      failures++;
      $display("FAIL first_instr: valid=%b instr=%h pc_out=%h req=%b, want 1 00100093 00000000 0",
               instr_valid, instruction, pc_out, imem_req);
    end
    imem_ack = 0;
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h4 || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL second_req: req=%b addr=%h valid=%b, want 1 00000004 0", imem_req, imem_addr, instr_valid);
    end
  endtask

  logic [31:0] held;

  task automatic test_delayed_ack();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h4 || instr_valid !== 1'b0) begin
        failures++;
        $display("FAIL wait_req[%0d]: req=%b addr=%h valid=%b, want 1 00000004 0", i, imem_req, imem_addr, instr_valid);
      end
      tick();
    end
    held = $urandom; imem_ack = 1; imem_rdata = held;
    tick();
    imem_ack = 0;
    checks++;
    if (instr_valid !== 1'b1 || pc_out !== 32'h4 || instruction !== held) begin
      failures++;
      $display("FAIL delayed_instr: valid=%b pc_out=%h instr=%h, want 1 00000004 %h", instr_valid, pc_out, instruction, held);
    end
  endtask

  task automatic test_stall();
    stall = 1;
    for (int i = 0; i < 4; i++) begin
      imem_rdata = $urandom;
      tick();
      checks++;
      if (instr_valid !== 1'b1 || pc_out !== 32'h4 || instruction !== held || imem_req !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold[%0d]: valid=%b pc_out=%h instr=%h req=%b, want 1 00000004 %h 0",
                 i, instr_valid, pc_out, instruction, imem_req, held);
      end
    end
    stall = 0;
    tick();
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h8) begin
      failures++;
      $display("FAIL stall_release: valid=%b req=%b addr=%h, want 0 1 00000008", instr_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_redirect_req();
    redirect = 1; redirect_pc = 32'h100;
    tick();
    redirect = 0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h8 || instr_valid !== 1'b0) begin
        failures++;
        $display("FAIL kill_stable[%0d]: req=%b addr=%h valid=%b, want 1 00000008 0", i, imem_req, imem_addr, instr_valid);
      end
      if (i == 0) tick();
    end
    imem_ack = 1; imem_rdata = $urandom;
    tick();
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      failures++;
      $display("FAIL kill_drop: valid=%b req=%b addr=%h, want 0 1 00000100", instr_valid, imem_req, imem_addr);
    end
    imem_rdata = 32'h1234_5678;
    tick();
    imem_ack = 0;
    checks++;
    if (instr_valid !== 1'b1 || pc_out !== 32'h100 || instruction !== 32'h1234_5678) begin
      failures++;
      $display("FAIL redirect_instr: valid=%b pc_out=%h instr=%h, want 1 00000100 12345678", instr_valid, pc_out, instruction);
    end
  endtask

  task automatic test_redirect_hold();
    stall = 1; redirect = 1; redirect_pc = 32'h40;
    tick();
    stall = 0; redirect = 0;
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
      failures++;
      $display("FAIL hold_flush: valid=%b req=%b addr=%h, want 0 1 00000040", instr_valid, imem_req, imem_addr);
    end
`ifndef FETCH_MISALIGN_TRAP_EN
    imem_ack = 1;
    tick();
    imem_ack = 0; redirect = 1; redirect_pc = 32'h83;
    tick();
    redirect = 0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h80) begin
      failures++;
      $display("FAIL align_force: req=%b addr=%h, want 1 00000080", imem_req, imem_addr);
    end
`endif
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      nRst = $urandom_range(99) != 0;
      stall = $urandom_range(2) == 0;
      redirect = $urandom_range(9) == 0;
`ifdef FETCH_MISALIGN_TRAP_EN
      redirect_pc = $urandom & 32'hFFFF_FFFC;
`else
      redirect_pc = $urandom;
`endif
      imem_ack = $urandom_range(1);
      imem_rdata = $urandom;
      tick();
      checks++;
      if (imem_req !== m_busy || imem_addr !== m_pc || instr_valid !== m_valid) begin
        failures++;
        $display("FAIL rand_ctl@%0d: req=%b addr=%h valid=%b, want %b %h %b",
                 c, imem_req, imem_addr, instr_valid, m_busy, m_pc, m_valid);
      end
      checks++;
      if (instruction !== m_instr || pc_out !== m_pcout) begin
        failures++;
        $display("FAIL rand_data@%0d: instr=%h pc_out=%h, want %h %h", c, instruction, pc_out, m_instr, m_pcout);
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      checks++;
      if (misaligned !== m_mis) begin
        failures++;
        $display("FAIL rand_mis@%0d: misaligned=%b, want %b", c, misaligned, m_mis);
      end
`endif
    end
  endtask

  task automatic test_wrap();
    stall = 0; redirect = 0; imem_ack = 0; nRst = 0;
    tick();
    nRst = 1;
    tick();
    checks++;
    if (req2 !== 1'b1 || addr2 !== 32'hFFFF_FFFC) begin
      failures++;
      $display("FAIL wrap_first: req=%b addr=%h, want 1 fffffffc", req2, addr2);
    end
    tick();
    checks++;
    if (valid2 !== 1'b1 || pc2 !== 32'hFFFF_FFFC || instr2 !== 32'h0010_0093) begin
      failures++;
      $display("FAIL wrap_instr: valid=%b pc_out=%h instr=%h, want 1 fffffffc 00100093", valid2, pc2, instr2);
    end
    tick();
    checks++;
    if (req2 !== 1'b1 || addr2 !== 32'h0) begin
      failures++;
      $display("FAIL wrap_second: req=%b addr=%h, want 1 00000000", req2, addr2);
    end
  endtask

`ifdef FETCH_MISALIGN_TRAP_EN
  task automatic test_misalign();
    imem_ack = 1;
    tick();
    imem_ack = 0; redirect = 1; redirect_pc = 32'h102;
    tick();
    checks++;
    if (misaligned !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL mis_enter: mis=%b req=%b valid=%b, want 1 0 0", misaligned, imem_req, instr_valid);
    end
    for (int i = 0; i < 4; i++) begin
      imem_ack = 1; stall = $urandom_range(1); redirect = $urandom_range(1); redirect_pc = 32'h200;
      tick();
      checks++;
      if (misaligned !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
        failures++;
        $display("FAIL mis_sticky[%0d]: mis=%b req=%b valid=%b, want 1 0 0", i, misaligned, imem_req, instr_valid);
      end
    end
    redirect = 0; nRst = 0;
    tick();
    checks++;
    if (misaligned !== 1'b0) begin
      failures++;
      $display("FAIL mis_clear: mis=%b, want 0", misaligned);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_zero_wait();
    test_delayed_ack();
    test_stall();
    test_redirect_req();
    test_redirect_hold();
    test_random();
    test_wrap();
`ifdef FETCH_MISALIGN_TRAP_EN
    test_misalign();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
